// File: rtl/lii_mem_endpoint_if.sv
// LII memory endpoint bundle: request stream, response stream and SRAM port.
//
// Signals
//   lii_req_*   request stream (header flit followed by write data beats)
//   lii_resp_*  response stream (read data beats or one write-ack flit)
//   mem_*       single-port synchronous SRAM, 1-cycle read latency
//
// Modports
//   slave   the endpoint: consumes requests, produces responses, drives the SRAM
//   master  the requester/test side: the mirror image of slave
interface lii_mem_endpoint_if #(
    parameter int unsigned AXI_DW = 256,
    parameter int unsigned LII_DW = 512,
    parameter int unsigned MEM_AW = 16
) ();
    logic [LII_DW-1:0]   lii_req_tdata;
    logic [LII_DW/8-1:0] lii_req_tkeep;
    logic [LII_DW/8-1:0] lii_req_tstrb;
    logic                lii_req_tlast;
    logic [7:0]          lii_req_src;
    logic [7:0]          lii_req_dst;
    logic                lii_req_tvalid;
    logic                lii_req_tready;

    logic [LII_DW-1:0]   lii_resp_tdata;
    logic [LII_DW/8-1:0] lii_resp_tkeep;
    logic [LII_DW/8-1:0] lii_resp_tstrb;
    logic                lii_resp_tlast;
    logic [7:0]          lii_resp_src;
    logic [7:0]          lii_resp_dst;
    logic                lii_resp_tvalid;
    logic                lii_resp_tready;

    logic [MEM_AW-1:0]   mem_addr;
    logic                mem_rd_en;
    logic                mem_wr_en;
    logic [AXI_DW-1:0]   mem_wdata;
    logic [AXI_DW/8-1:0] mem_wstrb;
    logic [AXI_DW-1:0]   mem_rdata;

    modport slave (
        input  lii_req_tdata, lii_req_tkeep, lii_req_tstrb, lii_req_tlast,
        input  lii_req_src, lii_req_dst, lii_req_tvalid,
        output lii_req_tready,
        output lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb, lii_resp_tlast,
        output lii_resp_src, lii_resp_dst, lii_resp_tvalid,
        input  lii_resp_tready,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output lii_req_tdata, lii_req_tkeep, lii_req_tstrb, lii_req_tlast,
        output lii_req_src, lii_req_dst, lii_req_tvalid,
        input  lii_req_tready,
        input  lii_resp_tdata, lii_resp_tkeep, lii_resp_tstrb, lii_resp_tlast,
        input  lii_resp_src, lii_resp_dst, lii_resp_tvalid,
        output lii_resp_tready,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mem_wstrb,
        output mem_rdata
    );
endinterface

// File: rtl/lii_mem_endpoint.sv
// LII memory endpoint: turns LII read/write request flits into SRAM accesses and
// returns read data beats or a single write-ack flit.
//
// Ports
//   clk   rising-edge clock
//   rstn  synchronous active-low reset
//   bus   lii_mem_endpoint_if.slave (request stream in, response stream out, SRAM port)
//
// Header flit (MSB first): op[2], len[8], size[3] (ignored), addr[AXI_AW], tag[8].
// Bursts are INCR, len+1 beats of AXI_DW bits each, one SRAM word per beat.
module lii_mem_endpoint #(
    parameter int unsigned AXI_AW = 48,
    parameter int unsigned AXI_DW = 256,
    parameter int unsigned LII_DW = 512,
    parameter int unsigned MEM_AW = 16
) (
    input logic               clk,
    input logic               rstn,
    lii_mem_endpoint_if.slave bus
);

    localparam int unsigned KeepW    = LII_DW / 8;
    localparam int unsigned StrbW    = AXI_DW / 8;
    localparam int unsigned ByteOffW = $clog2(AXI_DW / 8);
    localparam int unsigned AddrLo   = LII_DW - 13 - AXI_AW;
    localparam int unsigned TagLo    = AddrLo - 8;
    localparam int unsigned WordLo   = AddrLo + ByteOffW;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        WR_ACK
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        tag_q, tag_d;
    logic [7:0]        src_q, src_d;
    logic [7:0]        dst_q, dst_d;
    // Read: beat index. Write: accepted beat count, saturating so overlong
    // bursts can never wrap back onto len+1.
    logic [8:0]        beat_q, beat_d;
    logic [AXI_DW-1:0] rdata_q, rdata_d;
    // Set during the first RD_DATA cycle, while the SRAM output is still the
    // live source of the beat; afterwards rdata_q holds it across stalls.
    logic              fresh_q, fresh_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              req_ready;
    logic              resp_valid;
    logic              resp_last;
    logic [LII_DW-1:0] resp_data;
    logic [KeepW-1:0]  resp_keep;
    logic              mem_rd;
    logic              mem_wr;

    logic [1:0]        hdr_op;
    logic [7:0]        hdr_len;
    logic [MEM_AW-1:0] hdr_word;
    logic [7:0]        hdr_tag;
    logic [8:0]        beat_inc;
    logic [8:0]        beats_exp;
    logic              unused_req;

    assign hdr_op   = bus.lii_req_tdata[LII_DW-1 -: 2];
    assign hdr_len  = bus.lii_req_tdata[LII_DW-3 -: 8];
    assign hdr_word = bus.lii_req_tdata[WordLo +: MEM_AW];
    assign hdr_tag  = bus.lii_req_tdata[TagLo +: 8];

    assign beat_inc  = (beat_q == 9'h1ff) ? beat_q : beat_q + 9'd1;
    assign beats_exp = {1'b0, len_q} + 9'd1;

    // Size field, keep and unused data/strobe bits are intentionally ignored.
    assign unused_req = ^{bus.lii_req_tkeep, bus.lii_req_tstrb, bus.lii_req_tdata};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            tag_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
            fresh_q <= 1'b0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
            fresh_q <= fresh_d;
            bresp_q <= bresp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        src_d      = src_q;
        dst_d      = dst_q;
        beat_d     = beat_q;
        rdata_d    = rdata_q;
        fresh_d    = fresh_q;
        bresp_d    = bresp_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.lii_req_tvalid) begin
                    len_d  = hdr_len;
                    addr_d = hdr_word;
                    tag_d  = hdr_tag;
                    src_d  = bus.lii_req_src;
                    dst_d  = bus.lii_req_dst;
                    beat_d = '0;
                    unique case (hdr_op)
                        2'b00:   state_d = RD_REQ;
                        2'b01:   state_d = WR_DATA;
                        default: state_d = IDLE;
                    endcase
                end
            end

            RD_REQ: begin
                mem_rd  = 1'b1;
                fresh_d = 1'b1;
                state_d = RD_DATA;
            end

            RD_DATA: begin
                resp_valid = 1'b1;
                if (fresh_q) begin
                    rdata_d = bus.mem_rdata;
                    fresh_d = 1'b0;
                end
                if (bus.lii_resp_tready) begin
                    if (beat_q[7:0] == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 9'd1;
                        addr_d  = addr_q + 1'b1;
                        state_d = RD_REQ;
                    end
                end
            end

            WR_DATA: begin
                req_ready = 1'b1;
                if (bus.lii_req_tvalid) begin
                    // Beats past len+1 are swallowed without touching memory.
                    mem_wr = (beat_q < beats_exp);
                    addr_d = addr_q + 1'b1;
                    beat_d = beat_inc;
                    if (bus.lii_req_tlast) begin
                        bresp_d = (beat_inc == beats_exp) ? 2'b00 : 2'b10;
                        state_d = WR_ACK;
                    end
                end
            end

            WR_ACK: begin
                resp_valid = 1'b1;
                if (bus.lii_resp_tready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_data = '0;
        resp_keep = '0;
        resp_last = 1'b0;
        unique case (state_q)
            RD_DATA: begin
                resp_data[AXI_DW-1:0] = fresh_q ? bus.mem_rdata : rdata_q;
                resp_keep             = '1;
                resp_last             = (beat_q[7:0] == len_q);
            end
            WR_ACK: begin
                resp_data[1:0] = bresp_q;
                resp_last      = 1'b1;
            end
            default: ;
        endcase
        resp_data[LII_DW-1 -: 8] = tag_q;
    end

    // Handshake/enable outputs are gated by rstn so they read 0 for the whole
    // reset interval, not only after the first reset edge.
    assign bus.lii_req_tready  = rstn & req_ready;
    assign bus.lii_resp_tvalid = rstn & resp_valid;
    assign bus.lii_resp_tdata  = resp_data;
    assign bus.lii_resp_tkeep  = resp_keep;
    assign bus.lii_resp_tstrb  = resp_keep;
    assign bus.lii_resp_tlast  = resp_last;
    assign bus.lii_resp_src    = dst_q;
    assign bus.lii_resp_dst    = src_q;

    assign bus.mem_addr  = addr_q;
    assign bus.mem_rd_en = rstn & mem_rd;
    assign bus.mem_wr_en = rstn & mem_wr;
    assign bus.mem_wdata = bus.lii_req_tdata[AXI_DW-1:0];
    assign bus.mem_wstrb = bus.lii_req_tstrb[StrbW-1:0];

endmodule

// File: doc/lii_mem_endpoint.md
LII_MEM_ENDPOINT -- requirements
Module: lii_mem_endpoint

Interface
REQ-001 SHALL have parameter AXI_AW, default 48, header address width.
REQ-002 SHALL have parameter AXI_DW, default 256, data payload width.
REQ-003 SHALL have parameter LII_DW, default 512, LII flit width.
REQ-004 SHALL have parameter MEM_AW, default 16, memory word-address width.
REQ-005 SHALL have port clk, input, 1, clock; all logic is rising-edge.
REQ-006 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports lii_req_tdata/tkeep/tstrb/tlast/src/dst/tvalid, inputs, LII_DW/LII_DW/8/LII_DW/8/1/8/8/1, request stream; lii_req_tready, output, 1.
REQ-008 SHALL have ports lii_resp_tdata/tkeep/tstrb/tlast/src/dst/tvalid, outputs, same widths, response stream; lii_resp_tready, input, 1.
REQ-009 SHALL have ports mem_addr (output, MEM_AW), mem_rd_en (output, 1), mem_wr_en (output, 1), mem_wdata (output, AXI_DW), mem_wstrb (output, AXI_DW/8) and mem_rdata (input, AXI_DW); the memory is a synchronous SRAM with 1-cycle read latency.

Function
REQ-010 SHALL decode the header flit MSB-first: op[511:510] (00 read, 01 write), len[509:502], size[501:499], addr[498:451], tag[450:443].
REQ-011 SHALL ignore size; every beat is AXI_DW wide, the burst type is INCR, and the beat count is len+1.
REQ-012 SHALL set the start word address to addr[MEM_AW+4:5] and increment it by 1 per beat, wrapping modulo 2^MEM_AW.
REQ-013 SHALL use FSM states IDLE, RD_REQ, RD_DATA, WR_DATA and WR_ACK.
REQ-014 In IDLE, SHALL hold lii_req_tready=1; on a header handshake it SHALL capture len, the start word address, tag, src and dst, then go to RD_REQ (op 00), WR_DATA (op 01), or stay in IDLE and drop the flit (op 1x).
REQ-015 In RD_REQ, SHALL hold lii_req_tready=0, assert mem_rd_en for exactly one cycle with mem_addr set to the current address, and go to RD_DATA.
REQ-016 On entry to RD_DATA, SHALL register mem_rdata into the response data register.
REQ-017 In RD_DATA, SHALL present tvalid=1, tdata[AXI_DW-1:0]=the read data, tdata[511:504]=tag, all other tdata bits 0, tkeep and tstrb all ones, and tlast=1 only on beat len.
REQ-018 On an RD_DATA handshake, SHALL go to IDLE after the last beat, otherwise increment the address and go to RD_REQ; throughput is 1 beat per 2 cycles when tready=1.
REQ-019 While tready=0, SHALL hold every response output stable.
REQ-020 In WR_DATA, SHALL drive lii_req_tready=1; on each handshake, in the same cycle, SHALL assert mem_wr_en with mem_wdata=tdata[AXI_DW-1:0], mem_wstrb=tstrb[AXI_DW/8-1:0] and mem_addr=the current address, then increment the address and the beat counter.
REQ-021 In WR_DATA, SHALL suppress mem_wr_en for any beat beyond len+1 while still accepting it.
REQ-022 SHALL end the write burst only on a handshake with tlast=1, then go to WR_ACK.
REQ-023 SHALL set the write bresp to 00 if the accepted beat count equals len+1, and to 10 (SLVERR) otherwise.
REQ-024 In WR_ACK, SHALL drive tvalid=1, tlast=1, tkeep=0, tstrb=0, tdata[1:0]=bresp, tdata[511:504]=tag and all other tdata bits 0, and go to IDLE on handshake.
REQ-025 In WR_ACK, SHALL hold lii_req_tready=0.
REQ-026 SHALL set resp_src=captured req_dst and resp_dst=captured req_src on all response flits.
REQ-027 Outside RD_DATA and WR_ACK, SHALL drive lii_resp_tvalid=0.
REQ-028 Outside RD_REQ and WR_DATA, SHALL drive mem_rd_en=0 and mem_wr_en=0.
REQ-029 SHALL never assert mem_rd_en and mem_wr_en in the same cycle.

Reset
REQ-030 While rstn=0 at a clock edge, SHALL enter IDLE and clear the counters, address, tag, src/dst and data register.
REQ-031 While in reset, SHALL drive lii_resp_tvalid, mem_rd_en and mem_wr_en to 0, and lii_req_tready to 0.
REQ-032 On reset mid-burst, SHALL abort the burst with no further memory access and no response flit.

Verification
REQ-033 Read with len=3 and addr=0x40, tready=1 -> mem_rd_en at words 2,3,4,5; 4 beats, tkeep all ones, tlast on beat 4, tag echoed in [511:504].
REQ-034 Write with len=1 at addr=0x0 and data beats A,B with strobes 0xFFFFFFFF,0x0000FFFF, second beat tlast=1 -> mem_wr_en at words 0,1 with matching strobes; one ack flit with tkeep=0 and tdata[1:0]=00.
REQ-035 Write with len=2 but tlast on beat 2 -> 2 memory writes; ack tdata[1:0]=10.
REQ-036 Read with len=0 and lii_resp_tready=0 for 5 cycles -> tvalid held with data stable; exactly one mem_rd_en.
REQ-037 Header with op=11 -> flit accepted, no memory access, no response; a following valid read completes normally.
REQ-038 rstn=0 during beat 2 of a 4-beat read -> tvalid=0 on the next cycle; a new header is accepted after reset.
